// File: rtl/arbitro_roteamento_if.sv
// Requester/sink bundle for the roteamento 4:1 arbiter: request and data lines in,
// grant, select and the routed word with its valid/ready handshake out.
interface arbitro_roteamento_if #(
   parameter int unsigned N_BITS = 4
);
   logic [3:0]        req;
   logic [N_BITS-1:0] A;
   logic [N_BITS-1:0] B;
   logic [N_BITS-1:0] C;
   logic [N_BITS-1:0] D;
   logic              ready;
   logic [3:0]        gnt;
   logic [1:0]        SEL;
   logic              valid;
   logic [N_BITS-1:0] Saida;

   modport master (
      output req, A, B, C, D, ready,
      input  gnt, SEL, valid, Saida
   );

   modport slave (
      input  req, A, B, C, D, ready,
      output gnt, SEL, valid, Saida
   );
endinterface

// File: rtl/arbitro_roteamento.sv
// Round-robin arbiter and 4:1 router with bounded grants and an IDLE gap after every grant.
// Macro ARB_BURST_LIMIT_EN enables the MAX_BURST per-grant beat limit; undefined, grants end only on withdrawal.
module arbitro_roteamento #(
   parameter int unsigned N_BITS    = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   arbitro_roteamento_if.slave  bus
);

   if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_burst_range
      $error("MAX_BURST must be within 1..15");
   end

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t      state_q;
   logic [1:0]  sel_q;
   logic [1:0]  last_q;
   logic [3:0]  gnt_q;

   logic [1:0]  win_d;
   logic        win_found_d;
   logic [1:0]  cand;
   logic        req_sel;
   logic        valid;
   logic [N_BITS-1:0] saida_d;

`ifdef ARB_BURST_LIMIT_EN
   localparam logic [3:0] LastBeat = 4'(MAX_BURST - 1);
   logic [3:0]  cnt_q;
   logic        xfer;
`endif

   // Scan starts one past the previous grantee; k = 4 wraps back onto last_q itself.
   always_comb begin : rr_scan
      win_d       = '0;
      win_found_d = 1'b0;
      cand        = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!win_found_d && bus.req[cand]) begin
            win_d       = cand;
            win_found_d = 1'b1;
         end
      end
   end

   assign req_sel = bus.req[sel_q];
   assign valid   = (state_q == GRANT) && req_sel;

`ifdef ARB_BURST_LIMIT_EN
   assign xfer = valid && bus.ready;
`endif

   always_comb begin : data_mux
      saida_d = '0;
      case (sel_q)
         2'd0:    saida_d = bus.A;
         2'd1:    saida_d = bus.B;
         2'd2:    saida_d = bus.C;
         default: saida_d = bus.D;
      endcase
   end

   always_ff @(posedge clock) begin : fsm
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= '1;
`ifdef ARB_BURST_LIMIT_EN
         cnt_q   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (win_found_d) begin
                  state_q <= GRANT;
                  sel_q   <= win_d;
                  gnt_q   <= 4'b0001 << win_d;
`ifdef ARB_BURST_LIMIT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            GRANT: begin
               if (!req_sel) begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  last_q  <= sel_q;
`ifdef ARB_BURST_LIMIT_EN
                  cnt_q   <= '0;
               end else if (xfer) begin
                  if (cnt_q == LastBeat) begin
                     state_q <= IDLE;
                     gnt_q   <= '0;
                     last_q  <= sel_q;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q   <= cnt_q + 4'd1;
                  end
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.SEL   = sel_q;
   assign bus.valid = valid;
   assign bus.Saida = saida_d;

endmodule

// File: doc/arbitro_roteamento.md
# arbitro_roteamento

Round-robin arbiter and sequencer for the 4:1 routing multiplexer of the roteamento datapath. Four requesters (A, B, C, D) compete for a single N_BITS output channel. The block decides which source is granted, drives the registered select `SEL` and one-hot `gnt`, and routes the granted word to `Saida` with a valid/ready handshake toward the sink. Grants are bounded in length so that no requester can starve the others.

## Interface
- `N_BITS`, default 4: data word width.
- `MAX_BURST`, default 4: maximum transfers per grant. Legal range is 1..15.
- `clock`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req`, input, 4: `req[i]` is high while requester i has a word on its data port. Bit 0 is A, bit 1 is B, bit 2 is C, bit 3 is D.
- `A`, `B`, `C`, `D`, input, N_BITS each: requester data words.
- `ready`, input, 1: the sink accepts `Saida` this cycle.
- `gnt`, output, 4: one-hot grant, registered. All zero when no grant is active.
- `SEL`, output, 2: registered index of the current or most recent grantee.
- `valid`, output, 1: `Saida` holds a word offered to the sink.
- `Saida`, output, N_BITS: combinational mux of A/B/C/D, indexed by the registered `SEL`.

## Operation
- The FSM has two states, IDLE and GRANT. It also holds a 2-bit `last` register (the previous grantee) and a 4-bit beat counter `cnt`.
- Reset values: state = IDLE, `gnt` = 0000, `SEL` = 00, `last` = 11, `cnt` = 0, `valid` = 0. With reset values, priority after reset starts at requester 0.
- Arbitration in IDLE:
  - When `req` is nonzero, scan the requesters starting at `(last+1) mod 4`, wrapping at 3 to 0. The first requester i with `req[i]` set wins.
  - Next edge: state = GRANT, `SEL` = i, `gnt` = one-hot(i), `cnt` = 0.
  - When `req` = 0000, remain in IDLE; `SEL` and `last` keep their values.
- Handshake:
  - `valid` = (state == GRANT) & `req[SEL]`.
  - A transfer happens on any cycle with `valid` & `ready`.
  - A transfer increments `cnt`.
  - `Saida` follows `SEL` at all times, including in IDLE. The sink ignores `Saida` while `valid` = 0.
- Leaving GRANT. The next edge goes to IDLE with `gnt` = 0000, `last` = `SEL`, and `cnt` = 0 when either of these holds:
  - `req[SEL]` = 0 (requester withdrew). No transfer is counted that cycle.
  - A transfer occurs and `cnt` == MAX_BURST-1 (burst exhausted).
- Stall: while `ready` = 0, the grant is held indefinitely, `cnt` is frozen, and `Saida` and `valid` stay stable.
- Every grant is followed by exactly one IDLE cycle, even if the same requester wins again.
- Reset asserted in any state returns all registers to their reset values at the next edge. A transfer in flight that cycle is dropped.

## Timing
- Latency from `req` to grant: `req` seen in IDLE at cycle n gives `gnt`/`valid` high at cycle n+1.
- With continuous `ready` = 1 and the requester holding `req`, the grant lasts exactly MAX_BURST cycles, followed by 1 IDLE cycle.
- With all four requesting and `ready` = 1, the steady-state period is 4×(MAX_BURST+1) cycles and each requester gets MAX_BURST beats per period.
- When a requester withdraws, `gnt` falls at the edge after `req[SEL]` falls.

## Configuration
- `ARB_BURST_LIMIT_EN` defined: the MAX_BURST limit is enforced as described above.
- `ARB_BURST_LIMIT_EN` undefined:
  - `cnt` and the burst-exhausted exit are removed.
  - A grant ends only when `req[SEL]` drops or on reset.
  - `MAX_BURST` is ignored.

## Test plan
All scenarios use `MAX_BURST` = 4 and `ARB_BURST_LIMIT_EN` defined unless stated otherwise.
- Reset: hold `reset` for 2 cycles with `req` = 1111. Required: `gnt` = 0000, `SEL` = 00, `valid` = 0 throughout. The first grant is 0001, one cycle after reset is released.
- Single requester: `req` = 0001, `A` = 4'hA, `ready` = 1. Required:
  - `valid` = 1 with `Saida` = 4'hA for 4 cycles.
  - Then 1 cycle of `gnt` = 0000.
  - Then A is re-granted.
- Full rotation: `req` = 1111, data A..D = 1..4, `ready` = 1. Required: `SEL` sequence 0, 1, 2, 3, 0, with 4 beats each, one IDLE cycle between grants, and `Saida` = `SEL`+1 on every `valid` beat.
- Stall: C granted with `ready` = 0 for 10 cycles, then `ready` = 1. Required:
  - `gnt` = 0100 and `valid` = 1 held for all 10 cycles.
  - Then exactly 4 transfers before release.
- Withdrawal: `req` = 1100, C granted, `req[2]` dropped after 2 transfers. Required: `gnt` = 0000 at the next edge, then `gnt` = 1000 (D) one cycle later.
- Macro off: repeat the single-requester scenario with `ARB_BURST_LIMIT_EN` undefined. Required: `gnt` stays 0001 for 20+ cycles with no IDLE gap.
